// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : Oversampling UART receive engine. Synchronises the rx pin,
//               validates start bits, deserialises 8-bit LSB-first frames,
//               checks the stop bit and presents each byte through a
//               one-entry valid/ready holding register.
//               Optional parity support is compiled in with the macro
//               UART_RX_PARITY_EN (adds parity_odd / parity_err and a
//               PARITY state; otherwise frames are 8N1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             rx,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    output logic [7:0]       data,
    output logic             valid,
    input  logic             ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
`ifdef UART_RX_PARITY_EN
    ,
    input  logic             parity_odd,
    output logic             parity_err
`endif
);

    localparam int                c_SC_W    = $clog2(OVERSAMPLE);
    localparam logic [c_SC_W-1:0] c_SC_MID  = c_SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SC_W-1:0] c_SC_LAST = c_SC_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_rx_meta;
    logic               r_rxs;
    logic [DIV_W-1:0]   r_baud_cnt;
    logic [c_SC_W-1:0]  r_sc;
    logic [2:0]         r_bitcnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_tick;
    logic               w_sample;
    logic               w_sc_clr;
    logic               w_shift_en;
    logic               w_deliver;
    logic               w_ferr;
`ifdef UART_RX_PARITY_EN
    logic               r_parity_err;
    logic               w_perr;
`endif

    // Two-flop synchroniser for the asynchronous pin; idles high out of reset
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // Tick only while a frame is in progress so the phase is set by start detection
    assign w_tick   = enable && (r_state != S_IDLE) && (r_baud_cnt == baud_div);
    assign w_sample = w_tick && (r_sc == c_SC_LAST);

    // Baud divider: counts 0..baud_div, held at 0 when idle or disabled
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_baud_cnt <= '0;
        end else if (!enable || (r_state == S_IDLE) || w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
        end
    end

    // Sample counter: ticks within one bit; realigned after the mid-start sample
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_sc <= '0;
        end else if (!enable || (r_state == S_IDLE) || w_sc_clr) begin
            r_sc <= '0;
        end else if (w_tick) begin
            r_sc <= (r_sc == c_SC_LAST) ? '0 : r_sc + c_SC_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle strobes; losing enable aborts any frame
    always_comb begin
        w_state_nxt = r_state;
        w_sc_clr    = 1'b0;
        w_shift_en  = 1'b0;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr      = 1'b0;
`endif
        if ((r_state != S_IDLE) && !enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && !r_rxs) begin
                        w_state_nxt = S_START;
                    end
                end
                S_START: begin
                    if (w_tick && (r_sc == c_SC_MID)) begin
                        if (!r_rxs) begin
                            w_state_nxt = S_DATA;
                            w_sc_clr    = 1'b1;
                        end else begin
                            // Line went back high before mid-bit: a glitch
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        w_shift_en = 1'b1;
                        if (r_bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_sample) begin
                        w_perr      = (r_rxs != ((^r_shift) ^ parity_odd));
                        w_state_nxt = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_sample) begin
                        if (r_rxs) begin
                            w_deliver   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr      = 1'b1;
                            w_state_nxt = S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // A break holds the line low; rearm only once it is released
                    if (r_rxs) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Shift register (LSB first, enters at bit 7) and data-bit counter
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
        end else if (r_state != S_DATA) begin
            r_bitcnt <= 3'd0;
        end else if (w_shift_en) begin
            r_shift  <= {r_rxs, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
        end
    end

    // Holding register, valid flag and registered error pulses
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch pulse, one clock after the parity sample
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr;
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Directed self-checking bench for uart_rx_core. baud_div=3,
//               OVERSAMPLE=16, so one bit is 64 clocks. Frames are driven on
//               falling clock edges; outputs are sampled on falling edges.
//               Honours UART_RX_PARITY_EN (frames then carry a parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

`ifdef UART_RX_PARITY_EN
    localparam bit c_PAR = 1'b1;
`else
    localparam bit c_PAR = 1'b0;
`endif
    localparam int c_BIT = 64;
    // Clocks from the pin falling (just after edge k) to the load edge:
    // 2 synchroniser flops + 1 detect edge + (N/2 + (9|10)N) ticks of 4 clocks
    localparam int c_LOAD_WAIT = 3 + 4 * (8 + 16 * (9 + int'(c_PAR))) - 1;

    logic        clk;
    logic        nReset;
    logic        rx;
    logic        enable;
    logic [15:0] baud_div;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;
    logic        parity_odd;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    int n_vec;
    int n_miss;
    int n_ferr;
    int n_ovr;
    int n_perr;
    int f0;
    int o0;
    int p0;

    uart_rx_core #(
        .OVERSAMPLE (16),
        .DIV_W      (16)
    ) u_dut (
        .clk        (clk),
        .nReset     (nReset),
        .rx         (rx),
        .enable     (enable),
        .baud_div   (baud_div),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_odd (parity_odd),
        .parity_err (parity_err)
`endif
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count error pulses, sampled away from the active edge
    initial begin
        n_ferr = 0;
        n_ovr  = 0;
        n_perr = 0;
    end
    always @(negedge clk) begin
        if (frame_err) n_ferr = n_ferr + 1;
        if (overrun)   n_ovr  = n_ovr + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_perr = n_perr + 1;
`endif
    end

    // Single comparison point
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; must be called on a falling edge. Leaves rx high.
    task automatic send_frame(input logic [7:0] b, input logic par_bit,
                              input logic stop_lvl, input int stop_bits);
        rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_BIT) @(negedge clk);
        end
        if (c_PAR) begin
            rx = par_bit;
            repeat (c_BIT) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (c_BIT * stop_bits) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, (^b) ^ parity_odd, 1'b1, 1);
    endtask

    task automatic consume();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        nReset     = 1'b0;
        rx         = 1'b1;
        enable     = 1'b0;
        ready      = 1'b0;
        baud_div   = 16'd3;
        parity_odd = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        check_val("rst_data",  32'(data),      32'h00);
        check_val("rst_valid", 32'(valid),     32'h0);
        check_val("rst_busy",  32'(busy),      32'h0);
        check_val("rst_ferr",  32'(frame_err), 32'h0);
        check_val("rst_ovr",   32'(overrun),   32'h0);
        nReset = 1'b1;
        enable = 1'b1;
        repeat (10) @(negedge clk);

        // Basic receive of 0xA5
        f0 = n_ferr; o0 = n_ovr;
        send_ok(8'hA5);
        repeat (4) @(negedge clk);
        check_val("basic_valid", 32'(valid), 32'h1);
        check_val("basic_data",  32'(data),  32'hA5);
        check_val("basic_busy",  32'(busy),  32'h0);
        check_val("basic_ferr",  32'(n_ferr - f0), 32'd0);
        check_val("basic_ovr",   32'(n_ovr - o0),  32'd0);
        consume();
        check_val("basic_consumed", 32'(valid), 32'h0);
        repeat (20) @(negedge clk);

        // Glitch rejection: low for 4 ticks only
        rx = 1'b0;
        repeat (16) @(negedge clk);
        check_val("glitch_busy_hi", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check_val("glitch_busy_lo", 32'(busy),  32'h0);
        check_val("glitch_valid",   32'(valid), 32'h0);

        // Framing error with a 2-bit-long low stop, then recovery
        f0 = n_ferr;
        send_frame(8'h3C, (^8'h3C) ^ parity_odd, 1'b0, 2);
        check_val("ferr_wait_busy", 32'(busy), 32'h1);
        check_val("ferr_pulses",    32'(n_ferr - f0), 32'd1);
        check_val("ferr_valid",     32'(valid), 32'h0);
        repeat (6) @(negedge clk);
        check_val("ferr_idle", 32'(busy), 32'h0);
        send_ok(8'h11);
        repeat (4) @(negedge clk);
        check_val("ferr_next_valid", 32'(valid), 32'h1);
        check_val("ferr_next_data",  32'(data),  32'h11);
        check_val("ferr_next_pulses", 32'(n_ferr - f0), 32'd1);
        consume();
        repeat (20) @(negedge clk);

        // Overrun: two bytes with nobody draining
        o0 = n_ovr;
        send_ok(8'h3C);
        send_ok(8'h7E);
        repeat (4) @(negedge clk);
        check_val("ovr_data",   32'(data),  32'h3C);
        check_val("ovr_valid",  32'(valid), 32'h1);
        check_val("ovr_pulses", 32'(n_ovr - o0), 32'd1);
        consume();
        check_val("ovr_consumed", 32'(valid), 32'h0);
        repeat (20) @(negedge clk);

        // Back-to-back with ready on the exact load cycle
        send_ok(8'h3C);
        repeat (4) @(negedge clk);
        check_val("b2b_first", 32'(data), 32'h3C);
        o0 = n_ovr;
        fork
            send_ok(8'h7E);
            begin
                repeat (c_LOAD_WAIT) @(posedge clk);
                @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
                check_val("b2b_valid", 32'(valid), 32'h1);
                check_val("b2b_data",  32'(data),  32'h7E);
            end
        join
        repeat (4) @(negedge clk);
        check_val("b2b_ovr",   32'(n_ovr - o0), 32'd0);
        check_val("b2b_valid_hold", 32'(valid), 32'h1);

        // Asynchronous reset during bit 4 of 0xFF (0x7E still held)
        rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4 * c_BIT + 32) @(negedge clk);
        check_val("rstmid_busy_pre", 32'(busy), 32'h1);
        nReset = 1'b0;
        #1;
        check_val("rstmid_data",  32'(data),      32'h00);
        check_val("rstmid_valid", 32'(valid),     32'h0);
        check_val("rstmid_busy",  32'(busy),      32'h0);
        check_val("rstmid_ferr",  32'(frame_err), 32'h0);
        check_val("rstmid_ovr",   32'(overrun),   32'h0);
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        repeat (5 * c_BIT) @(negedge clk);
        check_val("rstmid_after", 32'(valid), 32'h0);

        // Disable mid-frame: holding register must survive, no new byte
        send_ok(8'h55);
        repeat (4) @(negedge clk);
        check_val("dis_pre_data", 32'(data), 32'h55);
        f0 = n_ferr; o0 = n_ovr;
        rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * c_BIT) @(negedge clk);
        check_val("dis_busy_pre", 32'(busy), 32'h1);
        enable = 1'b0;
        @(negedge clk);
        check_val("dis_busy", 32'(busy), 32'h0);
        repeat (8 * c_BIT) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        check_val("dis_valid", 32'(valid), 32'h1);
        check_val("dis_data",  32'(data),  32'h55);
        check_val("dis_ovr",   32'(n_ovr - o0),  32'd0);
        check_val("dis_ferr",  32'(n_ferr - f0), 32'd0);
        consume();
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, 1);
        repeat (4) @(negedge clk);
        check_val("par_ok_valid", 32'(valid), 32'h1);
        check_val("par_ok_data",  32'(data),  32'h07);
        check_val("par_ok_err",   32'(n_perr - p0), 32'd0);
        consume();
        repeat (20) @(negedge clk);
        send_frame(8'h07, 1'b0, 1'b1, 1);
        repeat (4) @(negedge clk);
        check_val("par_bad_err",   32'(n_perr - p0), 32'd1);
        check_val("par_bad_valid", 32'(valid), 32'h1);
        check_val("par_bad_data",  32'(data),  32'h07);
        consume();
        repeat (20) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
